// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the pmem port arbiter.
// FSM state, transaction owner, default address/data widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational IFU/LSU grant, one-hot {lsu,ifu}.
// Ports: ifu_valid, lsu_valid, last (rr build only), grant[1:0].
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  owner_e     last,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    priority case (1'b1)
`ifdef MEM_ARB_RR_EN
      (ifu_valid && lsu_valid):
        grant = (last == OWN_LSU) ? 2'b01 : 2'b10;
`endif
      lsu_valid: grant = 2'b10;
      ifu_valid: grant = 2'b01;
      default:   grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pmem port between IFU and LSU, one txn at a time,
// with response watchdog. Ports: ifu_req/resp, lsu_req/resp, mem_req/resp. Macro MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  output logic              ifu_resp_err,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              lsu_resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [1:0]          grant;
  logic                idle_ok;
  logic                issue;
  logic                resp;

`ifdef MEM_ARB_RR_EN
  owner_e              rr_q, rr_d;
`endif

  mem_arb_picker u_picker (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .last      (rr_q),
`endif
    .grant     (grant)
  );

  // Ready is held low while rst is high so reset cycles show all-zero outputs.
  assign idle_ok       = (state_q == IDLE) && !rst;
  assign ifu_req_ready = idle_ok && grant[0];
  assign lsu_req_ready = idle_ok && grant[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef MEM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (lsu_req_ready) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          wen_d   = lsu_req_wen;
          wdata_d = lsu_req_wdata;
          wmask_d = lsu_req_wmask & {MASK_W{lsu_req_wen}};
          state_d = ISSUE;
        end else if (ifu_req_ready) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_req_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          state_d = ISSUE;
        end
`ifdef MEM_ARB_RR_EN
        if (lsu_req_ready || ifu_req_ready) rr_d = owner_d;
`endif
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = wen_q ? '0 : mem_resp_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_q    <= OWN_LSU;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign issue = (state_q == ISSUE);
  assign resp  = (state_q == RESP);

  assign mem_req_valid = issue;
  assign mem_req_addr  = issue ? addr_q  : '0;
  assign mem_req_wen   = issue & wen_q;
  assign mem_req_wdata = issue ? wdata_q : '0;
  assign mem_req_wmask = issue ? wmask_q : '0;

  assign ifu_resp_valid = resp && (owner_q == OWN_IFU);
  assign ifu_resp_data  = ifu_resp_valid ? rdata_q : '0;
  assign ifu_resp_err   = ifu_resp_valid & err_q;
  assign lsu_resp_valid = resp && (owner_q == OWN_LSU);
  assign lsu_resp_data  = lsu_resp_valid ? rdata_q : '0;
  assign lsu_resp_err   = lsu_resp_valid & err_q;

endmodule
